// File: rtl/alu_input_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_input_loader_pkg
//  Description : Shared definitions for the ALU input loader and the ALU:
//                opcode encodings, default widths, debouncer state encoding
//                and button indices.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_input_loader_pkg;

  // Default datapath widths shared with the ALU
  localparam int NB_DATA_DEF = 4;
  localparam int NB_OP_DEF   = 6;

  // ALU opcode encodings
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  // Button slots inside the per-button vectors of the top level
  localparam int BTN_A  = 0;
  localparam int BTN_B  = 1;
  localparam int BTN_OP = 2;

  // Debounce FSM: stable low, qualifying a rise, stable high, qualifying a fall
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } deb_state_t;

endpackage : alu_input_loader_pkg
`default_nettype wire

// File: rtl/alu_input_loader_btn_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debouncer
//  Description : 2-FF synchroniser plus debounce FSM for one push-button.
//                A level change is accepted only after DEBOUNCE_CYCLES
//                consecutive stable synchronised samples; an accepted press
//                yields a single registered one-cycle pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debouncer
  import alu_input_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_pulse,
  output logic o_level
);

  localparam int              NB_CNT     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [NB_CNT-1:0] c_cnt_last = NB_CNT'(DEBOUNCE_CYCLES - 1);

  logic              r_btn_meta;
  logic              r_btn_s;
  deb_state_t        r_state;
  deb_state_t        w_state_next;
  logic [NB_CNT-1:0] r_count;
  logic [NB_CNT-1:0] w_count_next;
  logic              r_pulse;
  logic              w_pulse_next;

  // Bring the asynchronous button into the clock domain
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_btn_meta <= 1'b0;
      r_btn_s    <= 1'b0;
    end else begin
      r_btn_meta <= i_btn;
      r_btn_s    <= r_btn_meta;
    end
  end

  // FSM state, stability counter and registered load pulse
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE_LOW;
      r_count <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_pulse <= w_pulse_next;
    end
  end

  // Next state: count saturates at the last value, so it never wraps
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_pulse_next = 1'b0;
    case (r_state)
      IDLE_LOW: begin
        if (r_btn_s) begin
          w_state_next = WAIT_HIGH;
          w_count_next = '0;
        end
      end
      WAIT_HIGH: begin
        if (!r_btn_s) begin
          w_state_next = IDLE_LOW;
        end else if (r_count == c_cnt_last) begin
          w_state_next = IDLE_HIGH;
          w_pulse_next = 1'b1;
        end else begin
          w_count_next = r_count + NB_CNT'(1);
        end
      end
      IDLE_HIGH: begin
        if (!r_btn_s) begin
          w_state_next = WAIT_LOW;
          w_count_next = '0;
        end
      end
      WAIT_LOW: begin
        if (r_btn_s) begin
          w_state_next = IDLE_HIGH;
        end else if (r_count == c_cnt_last) begin
          w_state_next = IDLE_LOW;
        end else begin
          w_count_next = r_count + NB_CNT'(1);
        end
      end
      default: begin
        w_state_next = IDLE_LOW;
        w_count_next = '0;
      end
    endcase
  end

  assign o_pulse = r_pulse;
  assign o_level = (r_state == IDLE_HIGH) || (r_state == WAIT_LOW);

endmodule : btn_debouncer
`default_nettype wire

// File: rtl/alu_input_loader.sv
`default_nettype none
// ============================================================================
//  Module      : alu_input_loader
//  Description : Captures operand A, operand B and the opcode from the slide
//                switches on debounced push-button presses and holds them
//                for the ALU. o_valid rises once all three have been loaded.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_input_loader
  import alu_input_loader_pkg::*;
#(
  parameter int NB_DATA         = NB_DATA_DEF,
  parameter int NB_OP           = NB_OP_DEF,
  parameter int NB_SW           = 8,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic [NB_SW-1:0]   i_switches,
  input  logic               i_btn_a,
  input  logic               i_btn_b,
  input  logic               i_btn_op,
  output logic [NB_DATA-1:0] o_datoA,
  output logic [NB_DATA-1:0] o_datoB,
  output logic [NB_OP-1:0]   o_operation,
  output logic               o_valid
);

  localparam logic [NB_OP-1:0] c_op_reset = NB_OP'(OP_ADD);

  logic               r_rst_meta;
  logic               r_rst;
  logic [NB_SW-1:0]   r_sw_meta;
  logic [NB_SW-1:0]   r_sw_s;
  logic [2:0]         w_btn_raw;
  logic [2:0]         w_pulse;
  logic [2:0]         w_unused_level;
  logic               w_unused_sw;
  logic [NB_DATA-1:0] r_dato_a;
  logic [NB_DATA-1:0] r_dato_b;
  logic [NB_OP-1:0]   r_operation;
  logic [2:0]         r_loaded;
  logic               r_valid;

  // Reset asserts immediately and releases on a clock edge two cycles later
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_rst_meta <= 1'b1;
      r_rst      <= 1'b1;
    end else begin
      r_rst_meta <= 1'b0;
      r_rst      <= r_rst_meta;
    end
  end

  // Switch synchroniser; every load takes its value from r_sw_s
  always_ff @(posedge clk or posedge r_rst) begin
    if (r_rst) begin
      r_sw_meta <= '0;
      r_sw_s    <= '0;
    end else begin
      r_sw_meta <= i_switches;
      r_sw_s    <= r_sw_meta;
    end
  end

  assign w_btn_raw   = {i_btn_op, i_btn_b, i_btn_a};
  // Upper switch bits beyond the operand/opcode widths are not loaded anywhere
  assign w_unused_sw = ^r_sw_s;

  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    btn_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk     (clk),
      .i_reset (r_rst),
      .i_btn   (w_btn_raw[gi]),
      .o_pulse (w_pulse[gi]),
      .o_level (w_unused_level[gi])
    );
  end

  // Load registers; simultaneous pulses all load on the same edge
  always_ff @(posedge clk or posedge r_rst) begin
    if (r_rst) begin
      r_dato_a    <= '0;
      r_dato_b    <= '0;
      r_operation <= c_op_reset;
    end else begin
      if (w_pulse[BTN_A])  r_dato_a    <= r_sw_s[NB_DATA-1:0];
      if (w_pulse[BTN_B])  r_dato_b    <= r_sw_s[NB_DATA-1:0];
      if (w_pulse[BTN_OP]) r_operation <= r_sw_s[NB_OP-1:0];
    end
  end

  // Sticky loaded flags and registered valid, cleared only by reset
  always_ff @(posedge clk or posedge r_rst) begin
    if (r_rst) begin
      r_loaded <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_loaded <= r_loaded | w_pulse;
      r_valid  <= &r_loaded;
    end
  end

  assign o_datoA     = r_dato_a;
  assign o_datoB     = r_dato_b;
  assign o_operation = r_operation;
  assign o_valid     = r_valid;

endmodule : alu_input_loader
`default_nettype wire
